// File: rtl/count_60_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// count_60_ctrl_pkg
// Shared definitions for the mm:ss timekeeper controller.
//   state_t   : controller mode, 2-bit encoding visible on the 'state' port
//   KEY_*     : bit positions of the three pushbuttons inside the key vectors
// -----------------------------------------------------------------------------
package count_60_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;
    localparam int KEY_CLR  = 2;
    localparam int NUM_KEYS = 3;

endpackage

// File: rtl/count_60_ctrl_key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Rising-edge detector for one debounced, synchronous pushbutton level.
//   clk   : system clock
//   rst   : asynchronous active-high reset (clears the key history)
//   key   : button level
//   pulse : high for the cycle in which 'key' is high and was low last cycle
// The pulse is combinational so the consumer can register its reaction on the
// same edge that first samples the key high.
// -----------------------------------------------------------------------------
module key_edge
    import count_60_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    logic r_key_d;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_d <= 1'b0;
        end else begin
            r_key_d <= key;
        end
    end

    assign pulse = key & ~r_key_d;

endmodule

// File: rtl/count_60_ctrl.sv
// -----------------------------------------------------------------------------
// count_60_ctrl
// Mode and enable sequencer for a mm:ss timekeeper made of two count_60 BCD
// counters. Divides clk into a seconds tick, runs the STOP/RUN/SET_MIN/SET_SEC
// state machine from three pushbuttons, and drives the counters' enables and
// clear. Holds no time value itself.
//   TICK_DIV  : clk cycles per seconds tick (must be >= 2)
//   clk, rst  : system clock, asynchronous active-high reset
//   key_mode  : mode button level (cycles through the set modes)
//   key_inc   : start/pause/increment button level
//   key_clr   : clear button level
//   sec_co    : seconds counter reads 59
//   min_co    : minutes counter reads 59
//   sec_en    : one-cycle enable to the seconds counter
//   min_en    : one-cycle enable to the minutes counter
//   cnt_clr   : one-cycle clear to both counters
//   hour_tick : one-cycle pulse on the 59:59 -> 00:00 rollover
//   state     : current mode (STOP=0, RUN=1, SET_MIN=2, SET_SEC=3)
// All outputs are registered.
// -----------------------------------------------------------------------------
module count_60_ctrl
    import count_60_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_clr,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_en,
    output logic       min_en,
    output logic       cnt_clr,
    output logic       hour_tick,
    output logic [1:0] state
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    // ---------------------------------------------------------------- keys
    logic [NUM_KEYS-1:0] w_key_lvl;
    logic [NUM_KEYS-1:0] w_key_rise;

    assign w_key_lvl[KEY_MODE] = key_mode;
    assign w_key_lvl[KEY_INC]  = key_inc;
    assign w_key_lvl[KEY_CLR]  = key_clr;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_edge u_key_edge (
            .clk   (clk),
            .rst   (rst),
            .key   (w_key_lvl[gi]),
            .pulse (w_key_rise[gi])
        );
    end

    // Only one event acts per cycle: clr beats mode beats inc.
    logic w_ev_clr;
    logic w_ev_mode;
    logic w_ev_inc;

    assign w_ev_clr  = w_key_rise[KEY_CLR];
    assign w_ev_mode = w_key_rise[KEY_MODE] & ~w_key_rise[KEY_CLR];
    assign w_ev_inc  = w_key_rise[KEY_INC]  & ~w_key_rise[KEY_CLR] & ~w_key_rise[KEY_MODE];

    // ----------------------------------------------------------- registers
    state_t         r_state;
    logic [PW-1:0]  r_presc;
    logic           r_sec_en;
    logic           r_min_en;
    logic           r_cnt_clr;
    logic           r_hour_tick;

    state_t         w_state_nxt;
    logic [PW-1:0]  w_presc_nxt;
    logic           w_sec_en_nxt;
    logic           w_min_en_nxt;
    logic           w_cnt_clr_nxt;
    logic           w_hour_tick_nxt;

    // ------------------------------------------------ next state / outputs
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt     = r_state;
        w_presc_nxt     = r_presc;
        w_sec_en_nxt    = 1'b0;
        w_min_en_nxt    = 1'b0;
        w_cnt_clr_nxt   = 1'b0;
        w_hour_tick_nxt = 1'b0;

        case (r_state)
            ST_STOP: begin
                // Prescaler holds, so a pause keeps the sub-second phase.
                if (w_ev_inc) begin
                    w_state_nxt = ST_RUN;
                end else if (w_ev_mode) begin
                    w_state_nxt = ST_SET_MIN;
                end
            end

            ST_RUN: begin
                // The wrap is honoured even when a key event leaves RUN on the
                // same edge; the counters still get their tick.
                if (r_presc == PRESC_MAX) begin
                    w_presc_nxt     = '0;
                    w_sec_en_nxt    = 1'b1;
                    w_min_en_nxt    = sec_co;
                    w_hour_tick_nxt = sec_co & min_co;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
                if (w_ev_inc) begin
                    w_state_nxt = ST_STOP;
                end else if (w_ev_mode) begin
                    w_state_nxt = ST_SET_MIN;
                end
            end

            ST_SET_MIN: begin
                // min_co is ignored: the minutes counter wraps by itself.
                w_presc_nxt = '0;
                if (w_ev_inc) begin
                    w_min_en_nxt = 1'b1;
                end else if (w_ev_mode) begin
                    w_state_nxt = ST_SET_SEC;
                end
            end

            ST_SET_SEC: begin
                // sec_co is ignored: setting seconds never carries into minutes.
                w_presc_nxt = '0;
                if (w_ev_inc) begin
                    w_sec_en_nxt = 1'b1;
                end else if (w_ev_mode) begin
                    w_state_nxt = ST_STOP;
                end
            end

            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase

        if (w_ev_clr) begin
            w_cnt_clr_nxt = 1'b1;
            w_presc_nxt   = '0;
            w_state_nxt   = ST_STOP;
        end
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STOP;
            r_presc     <= '0;
            r_sec_en    <= 1'b0;
            r_min_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_hour_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_presc     <= w_presc_nxt;
            r_sec_en    <= w_sec_en_nxt;
            r_min_en    <= w_min_en_nxt;
            r_cnt_clr   <= w_cnt_clr_nxt;
            r_hour_tick <= w_hour_tick_nxt;
        end
    end

    assign sec_en    = r_sec_en;
    assign min_en    = r_min_en;
    assign cnt_clr   = r_cnt_clr;
    assign hour_tick = r_hour_tick;
    assign state     = r_state;

endmodule

// File: tb/tb_count_60_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_60_ctrl
// Self-checking bench for count_60_ctrl with TICK_DIV=4. A behavioural model
// (mode number, sub-second phase, key history) predicts every output each
// cycle; directed steps add pulse-count and spacing checks.
// -----------------------------------------------------------------------------
module tb_count_60_ctrl;

    localparam int TICK_DIV = 4;

    localparam int MS_STOP    = 0;
    localparam int MS_RUN     = 1;
    localparam int MS_SET_MIN = 2;
    localparam int MS_SET_SEC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode;
    logic       key_inc;
    logic       key_clr;
    logic       sec_co;
    logic       min_co;
    logic       sec_en;
    logic       min_en;
    logic       cnt_clr;
    logic       hour_tick;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    count_60_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_clr   (key_clr),
        .sec_co    (sec_co),
        .min_co    (min_co),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .cnt_clr   (cnt_clr),
        .hour_tick (hour_tick),
        .state     (state)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ model
    int m_state;
    int m_phase;
    bit m_hm, m_hi, m_hc;
    bit x_sec, x_min, x_clr, x_hour;

    // bench-side observation counters
    int cyc;
    int n_sec, n_min, n_clr, n_hour;
    int last_sec, sec_gap;

    task automatic model_reset();
        m_state = MS_STOP;
        m_phase = 0;
        m_hm = 1'b0; m_hi = 1'b0; m_hc = 1'b0;
        x_sec = 1'b0; x_min = 1'b0; x_clr = 1'b0; x_hour = 1'b0;
    endtask

    task automatic model_step(input bit km, input bit ki, input bit kc,
                              input bit sc, input bit mc);
        bit e_clr, e_mode, e_inc, tick;
        e_clr  = kc && !m_hc;
        e_mode = km && !m_hm && !e_clr;
        e_inc  = ki && !m_hi && !e_clr && !e_mode;
        m_hm = km; m_hi = ki; m_hc = kc;

        x_sec = 1'b0; x_min = 1'b0; x_clr = 1'b0; x_hour = 1'b0;
        tick  = 1'b0;

        // Seconds phase: advances only while running, forced to 0 while setting.
        if (m_state == MS_RUN) begin
            m_phase = (m_phase + 1) % TICK_DIV;
            tick    = (m_phase == 0);
        end else if (m_state >= MS_SET_MIN) begin
            m_phase = 0;
        end

        if (tick) begin
            x_sec  = 1'b1;
            x_min  = sc;
            x_hour = sc && mc;
        end
        if (e_inc && m_state == MS_SET_MIN) x_min = 1'b1;
        if (e_inc && m_state == MS_SET_SEC) x_sec = 1'b1;

        if (e_clr) begin
            x_clr   = 1'b1;
            m_phase = 0;
            m_state = MS_STOP;
        end else if (e_mode) begin
            m_state = (m_state == MS_SET_MIN) ? MS_SET_SEC :
                      (m_state == MS_SET_SEC) ? MS_STOP : MS_SET_MIN;
        end else if (e_inc && m_state <= MS_RUN) begin
            m_state = (m_state == MS_RUN) ? MS_STOP : MS_RUN;
        end
    endtask

    // ------------------------------------------------------------ checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, step the model at posedge, compare #1 later.
    task automatic cycle(input bit km, input bit ki, input bit kc,
                         input bit sc, input bit mc);
        @(negedge clk);
        key_mode = km; key_inc = ki; key_clr = kc; sec_co = sc; min_co = mc;
        @(posedge clk);
        model_step(km, ki, kc, sc, mc);
        #1;
        cyc++;
        check("state",     32'(state),     32'(m_state));
        check("sec_en",    32'(sec_en),    32'(x_sec));
        check("min_en",    32'(min_en),    32'(x_min));
        check("cnt_clr",   32'(cnt_clr),   32'(x_clr));
        check("hour_tick", 32'(hour_tick), 32'(x_hour));
        if (sec_en === 1'b1) begin
            n_sec++;
            sec_gap  = cyc - last_sec;
            last_sec = cyc;
        end
        if (min_en === 1'b1)    n_min++;
        if (cnt_clr === 1'b1)   n_clr++;
        if (hour_tick === 1'b1) n_hour++;
    endtask

    task automatic idle(input int n, input bit sc, input bit mc);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, sc, mc);
    endtask

    task automatic press(input bit km, input bit ki, input bit kc,
                         input bit sc, input bit mc);
        cycle(km, ki, kc, sc, mc);
        cycle(1'b0, 1'b0, 1'b0, sc, mc);
    endtask

    task automatic clear_counts();
        n_sec = 0; n_min = 0; n_clr = 0; n_hour = 0;
    endtask

    // Bounded wait for the next seconds tick; an expired budget is a failure.
    task automatic wait_sec(input int budget, input bit sc, input bit mc);
        int k;
        k = 0;
        do begin
            cycle(1'b0, 1'b0, 1'b0, sc, mc);
            k++;
        end while (sec_en !== 1'b1 && k < budget);
        check("wait_sec_seen", 32'(sec_en), 32'd1);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int t_resume;
        cyc = 0; last_sec = 0; sec_gap = 0;
        clear_counts();
        rst = 1'b1;
        key_mode = 1'b0; key_inc = 1'b0; key_clr = 1'b0;
        sec_co = 1'b0; min_co = 1'b0;
        model_reset();

        // Reset state
        #1;
        check("rst_state",   32'(state),   32'd0);
        check("rst_sec_en",  32'(sec_en),  32'd0);
        check("rst_min_en",  32'(min_en),  32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_hour",    32'(hour_tick), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Start: RUN one cycle after the press, then a tick every 4 cycles
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_state_run", 32'(state), 32'd1);
        clear_counts();
        idle(12, 1'b0, 1'b0);
        check("run_tick_count", 32'(n_sec), 32'd3);
        check("run_tick_gap",   32'(sec_gap), 32'(TICK_DIV));
        check("run_last_tick",  32'(sec_en), 32'd1);

        // Carry into minutes, then full hour rollover
        clear_counts();
        idle(4, 1'b1, 1'b0);
        check("carry_min_en", 32'(min_en), 32'd1);
        check("carry_count",  32'(n_min),  32'd1);
        check("carry_no_hour", 32'(n_hour), 32'd0);
        clear_counts();
        idle(4, 1'b1, 1'b1);
        check("hour_tick_pulse", 32'(hour_tick), 32'd1);
        check("hour_tick_count", 32'(n_hour), 32'd1);

        // Pause with the phase parked at 2, resume -> tick 2 cycles later
        idle(1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_state", 32'(state), 32'd0);
        clear_counts();
        idle(3, 1'b0, 1'b0);
        check("pause_no_tick", 32'(n_sec), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        t_resume = cyc;
        wait_sec(10, 1'b0, 1'b0);
        check("resume_tick_delay", 32'(cyc - t_resume), 32'd2);

        // Set modes: 3 minute increments, then 1 second increment with sec_co
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("set_min_state", 32'(state), 32'd2);
        clear_counts();
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("set_min_count", 32'(n_min), 32'd3);
        check("set_min_no_sec", 32'(n_sec), 32'd0);
        check("set_min_no_hour", 32'(n_hour), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("set_sec_state", 32'(state), 32'd3);
        clear_counts();
        press(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("set_sec_count", 32'(n_sec), 32'd1);
        check("set_sec_no_min", 32'(n_min), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("set_back_stop", 32'(state), 32'd0);

        // clr + mode + inc together in RUN: clear wins, nothing else happens
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_sec(8, 1'b0, 1'b0);
        clear_counts();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("triple_cnt_clr", 32'(cnt_clr), 32'd1);
        check("triple_state",   32'(state),   32'd0);
        check("triple_sec_en",  32'(sec_en),  32'd0);
        check("triple_min_en",  32'(min_en),  32'd0);
        idle(6, 1'b0, 1'b0);
        check("triple_clr_once", 32'(n_clr), 32'd1);
        check("triple_no_ticks", 32'(n_sec), 32'd0);

        // Held key in SET_SEC acts once
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_counts();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b0, 1'b0);
        check("held_inc_sec_once", 32'(n_sec), 32'd1);
        check("held_inc_no_min",   32'(n_min), 32'd0);

        // Randomized key activity against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
        end

        // Reset asserted while sec_en is high drops everything at once
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_sec(8, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_sec_en",  32'(sec_en),    32'd0);
        check("async_rst_min_en",  32'(min_en),    32'd0);
        check("async_rst_hour",    32'(hour_tick), 32'd0);
        check("async_rst_cnt_clr", 32'(cnt_clr),   32'd0);
        check("async_rst_state",   32'(state),     32'd0);
        key_mode = 1'b0; key_inc = 1'b0; key_clr = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_60_ctrl.md
# count_60_ctrl

Mode and enable sequencer for a mm:ss timekeeper built from two `count_60` BCD counters: one for seconds, one for minutes. It divides the system clock into a 1-per-second tick and drives the counters' `en` inputs. It owns the run/stop/set state machine, driven by three pushbutton inputs. It issues the counters' clear. The controller holds no time value; it only sequences the counters.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per seconds tick. Legal range is ≥ 2. The prescaler width is clog2(TICK_DIV).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `key_mode` input 1: mode button, level. It is debounced and synchronous upstream.
- `key_inc` input 1: start/pause/increment button, level. It is debounced and synchronous.
- `key_clr` input 1: clear button, level. It is debounced and synchronous.
- `sec_co` input 1: high while the seconds counter reads 59.
- `min_co` input 1: high while the minutes counter reads 59.
- `sec_en` output 1: one-cycle enable to the seconds counter.
- `min_en` output 1: one-cycle enable to the minutes counter.
- `cnt_clr` output 1: one-cycle clear pulse to both counters. It drives their `rst`.
- `hour_tick` output 1: one-cycle pulse on the 59:59 → 00:00 rollover.
- `state` output 2: current mode. STOP=0, RUN=1, SET_MIN=2, SET_SEC=3.

## Operation
- Each key is rising-edge detected against a registered copy of itself. A held key acts once per press.
- Event priority within one cycle is clr > mode > inc. Lower-priority edges in that same cycle are discarded.
- `key_clr` in any state:
  - `cnt_clr` pulses.
  - The prescaler is set to 0.
  - The state goes to STOP.
- STOP (the reset state):
  - No enables are issued and the prescaler holds its value, so pause keeps the sub-second phase.
  - `key_inc` goes to RUN.
  - `key_mode` goes to SET_MIN.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - On wrap, `sec_en` pulses.
  - `min_en` pulses in the same cycle iff `sec_co`=1 at the wrap.
  - `hour_tick` pulses in the same cycle iff `sec_co`=1 and `min_co`=1 at the wrap.
  - `key_inc` goes to STOP (pause).
  - `key_mode` goes to SET_MIN.
- SET_MIN:
  - The prescaler is forced to 0.
  - Each `key_inc` edge pulses `min_en` once. `min_co` is ignored, so minutes wrap 59→00 on their own and no hour_tick is issued.
  - `key_mode` goes to SET_SEC.
- SET_SEC:
  - The prescaler is forced to 0.
  - Each `key_inc` edge pulses `sec_en` only. `min_en` stays 0 even when `sec_co`=1.
  - `key_mode` goes to STOP.
- If a prescaler wrap coincides with a mode or clr edge in RUN:
  - The wrap's pulses are still issued.
  - The state change takes effect at the same edge.
- `sec_co` and `min_co` are only sampled at a wrap or an increment. They are stable then because the counters change only on the enables.

## Timing
- All outputs are registered.
- Reset values: `sec_en`=0, `min_en`=0, `cnt_clr`=0, `hour_tick`=0, `state`=STOP. Reset also clears the prescaler and the key history registers.
- Key latency: key first sampled high at edge E gives the output pulse and new state in the cycle after E, i.e. 1 cycle.
- Tick spacing in RUN: exactly TICK_DIV cycles between `sec_en` pulses.
- First tick after leaving STOP with prescaler value P: TICK_DIV-P cycles later.
- All pulses last exactly one cycle. No output is high for two consecutive cycles except `sec_en` when TICK_DIV=1, which is illegal.
- `rst` asserted mid-pulse drops all outputs immediately, asynchronously.

## Structure
- Package `count_60_ctrl_pkg`: state enum encoding (STOP/RUN/SET_MIN/SET_SEC, 2 bits) and the key-index constants.
- Sub-module `key_edge` with ports `clk`, `rst`, `key`, `pulse`. It is instantiated three times.
- The FSM, prescaler and output registers live in the top module.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `key_inc` press → `state`=RUN 1 cycle later; `sec_en` pulses every 4 cycles thereafter.
- In RUN with `sec_co`=1 at a wrap → `sec_en`=`min_en`=1 in the same cycle. With `min_co`=1 as well → `hour_tick`=1 too.
- RUN with the prescaler at 2, press `key_inc` (pause) then `key_inc` again → the next `sec_en` comes 2 cycles after resume.
- Press `key_mode` from STOP, then 3 `key_inc` presses → 3 `min_en` pulses and 0 `sec_en`. Press `key_mode` again, then 1 `key_inc` with `sec_co`=1 → 1 `sec_en` and `min_en`=0. Press `key_mode` again → STOP.
- `key_clr`, `key_mode` and `key_inc` all rising in the same cycle while in RUN → one `cnt_clr` pulse, `state`=STOP, no enables.
- Hold `key_inc` high for 20 cycles in SET_SEC → exactly 1 `sec_en`. Assert `rst` mid-run → all outputs 0 and `state`=STOP immediately.
